// File: rtl/lcd_step_controller_pkg.sv
// rtl/lcd_step_controller_pkg.sv - HD44780 command constants and sequencer encodings
package lcd_step_controller_pkg;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int BUF_DEPTH = 32;
  localparam int INIT_CMDS = 4;
  localparam int CLEAR_IDX = 2;

  typedef enum logic [2:0] {
    INIT,
    ADDR1,
    CHARS1,
    ADDR2,
    CHARS2
  } state_t;

  typedef enum logic [1:0] {
    SETUP,
    PULSE,
    HOLD
  } phase_t;

  // Init order: function set, display control, clear, entry mode.
  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx,
    input logic [7:0] func_set,
    input logic [7:0] disp_ctrl,
    input logic [7:0] entry_mode
  );
    case (idx)
      2'd0:    return func_set;
      2'd1:    return disp_ctrl;
      2'd2:    return CLEAR;
      default: return entry_mode;
    endcase
  endfunction

endpackage

// File: rtl/lcd_step_controller_if.sv
// rtl/lcd_step_controller_if.sv - Host write port and LCD pin bundle
interface lcd_step_controller_if;

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       init_done;
  logic       frame_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, init_done, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, init_done, frame_done
  );

endinterface

// File: rtl/lcd_step_edge.sv
// rtl/lcd_step_edge.sv - Rising-edge detector for the divider step clock
module lcd_step_edge (
  input  logic clock_in,
  input  logic reset,
  input  logic step_clk,
  output logic step
);

  logic step_prev;

  // Resetting to 1 suppresses a step when step_clk is already high at release.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      step_prev <= 1'b1;
    end else begin
      step_prev <= step_clk;
    end
  end

  assign step = step_clk & ~step_prev;

endmodule

// File: rtl/lcd_step_controller.sv
// rtl/lcd_step_controller.sv - Step-paced HD44780 init and 2x16 refresh sequencer
module lcd_step_controller #(
  parameter logic [7:0] FUNC_SET         = 8'h38,
  parameter logic [7:0] DISP_CTRL        = 8'h0C,
  parameter logic [7:0] ENTRY_MODE       = 8'h06,
  parameter int         CLEAR_WAIT_STEPS = 2
) (
  input logic                   clock_in,
  input logic                   reset,
  input logic                   step_clk,
  lcd_step_controller_if.slave  bus
);

  import lcd_step_controller_pkg::*;

  logic step;

  lcd_step_edge u_step_edge (
    .clock_in (clock_in),
    .reset    (reset),
    .step_clk (step_clk),
    .step     (step)
  );

  logic [7:0] char_buf [BUF_DEPTH];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        char_buf[i] <= 8'h20;
      end
    end else if (bus.wr_en) begin
      char_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  state_t     state, state_n;
  phase_t     phase, phase_n;
  logic [4:0] idx, idx_n;
  logic [7:0] wait_cnt, wait_n;
  logic [7:0] data_q, data_n;
  logic       rs_q, rs_n;
  logic       en_q, en_n;
  logic       init_q, init_n;
  logic       frame_q, frame_n;
  logic [7:0] cur_byte;
  logic       cur_rs;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= INIT;
      phase    <= SETUP;
      idx      <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      init_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
      data_q   <= data_n;
      rs_q     <= rs_n;
      en_q     <= en_n;
      init_q   <= init_n;
      frame_q  <= frame_n;
    end
  end

  // Byte the current transaction would latch at its SETUP step.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    unique case (state)
      INIT:   cur_byte = init_cmd(idx[1:0], FUNC_SET, DISP_CTRL, ENTRY_MODE);
      ADDR1:  cur_byte = LINE1_ADDR;
      ADDR2:  cur_byte = LINE2_ADDR;
      CHARS1,
      CHARS2: begin
        cur_byte = char_buf[idx];
        cur_rs   = 1'b1;
      end
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    wait_n  = wait_cnt;
    data_n  = data_q;
    rs_n    = rs_q;
    en_n    = en_q;
    init_n  = init_q;
    frame_n = 1'b0;

    if (step) begin
      if (wait_cnt != 8'd0) begin
        wait_n = wait_cnt - 8'd1;
      end else begin
        unique case (phase)
          SETUP: begin
            data_n  = cur_byte;
            rs_n    = cur_rs;
            en_n    = 1'b0;
            phase_n = PULSE;
          end
          PULSE: begin
            en_n    = 1'b1;
            phase_n = HOLD;
          end
          HOLD: begin
            en_n    = 1'b0;
            phase_n = SETUP;
            idx_n   = idx + 5'd1;
            unique case (state)
              INIT: begin
                if (idx == 5'(INIT_CMDS - 1)) begin
                  idx_n   = '0;
                  init_n  = 1'b1;
                  state_n = ADDR1;
                end else if (idx == 5'(CLEAR_IDX)) begin
                  wait_n = 8'(CLEAR_WAIT_STEPS);
                end
              end
              ADDR1: begin
                idx_n   = idx;
                state_n = CHARS1;
              end
              CHARS1: begin
                if (idx == 5'd15) begin
                  state_n = ADDR2;
                end
              end
              ADDR2: begin
                idx_n   = idx;
                state_n = CHARS2;
              end
              CHARS2: begin
                // idx wraps 31 -> 0 on this same step.
                if (idx == 5'd31) begin
                  state_n = ADDR1;
                  frame_n = 1'b1;
                end
              end
              default: state_n = INIT;
            endcase
          end
          default: phase_n = SETUP;
        endcase
      end
    end
  end

  assign bus.lcd_data   = data_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = en_q;
  assign bus.init_done  = init_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_lcd_step_controller.sv
// tb/tb_lcd_step_controller.sv - Self-checking bench for lcd_step_controller
module tb_lcd_step_controller;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  logic step_clk = 1'b1;

  lcd_step_controller_if bus ();

  lcd_step_controller dut (
    .clock_in (clock_in),
    .reset    (reset),
    .step_clk (step_clk),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         step;
  } txn_t;

  typedef struct {
    int         wstep;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  txn_t mon_q[$];
  txn_t exp_q[$];
  int   fd_q[$];
  int   exp_fd[$];
  wr_t  wlog[$];

  int   checks     = 0;
  int   errors     = 0;
  int   step_cnt   = 0;
  int   model_step = 0;
  int   fd_wide    = 0;
  logic prev_en    = 1'b0;
  logic prev_fd    = 1'b0;
  txn_t mon_t;

  // Records every enable pulse with the step number that raised it.
  always @(negedge clock_in) begin
    if (bus.lcd_en && !prev_en) begin
      mon_t.rs   = bus.lcd_rs;
      mon_t.data = bus.lcd_data;
      mon_t.step = step_cnt;
      mon_q.push_back(mon_t);
    end
    if (bus.frame_done) begin
      fd_q.push_back(step_cnt);
      if (prev_fd) fd_wide++;
    end
    prev_en = bus.lcd_en;
    prev_fd = bus.frame_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic clear_model();
    mon_q.delete();
    exp_q.delete();
    fd_q.delete();
    exp_fd.delete();
    wlog.delete();
    step_cnt   = 0;
    model_step = 0;
  endtask

  task automatic log_write(input int s, input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.wstep = s;
    w.addr  = a;
    w.data  = d;
    wlog.push_back(w);
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    log_write(step_cnt, a, d);
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_step(input logic wr, input logic [4:0] a, input logic [7:0] d);
    step_clk = 1'b0;
    tick(5);
    step_clk = 1'b1;
    step_cnt++;
    if (wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      log_write(step_cnt, a, d);
    end
    tick(1);
    bus.wr_en = 1'b0;
    tick(4);
  endtask

  task automatic run_steps(input int n, input bit rand_wr);
    for (int i = 0; i < n; i++) begin
      do_step(1'b0, 5'd0, 8'd0);
      if (rand_wr && $urandom_range(0, 7) == 0)
        write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
  endtask

  // A character latched at step s sees only writes made strictly before s.
  function automatic logic [7:0] char_at(input int k, input int s);
    logic [7:0] v;
    v = 8'h20;
    foreach (wlog[i])
      if (wlog[i].addr == 5'(k) && wlog[i].wstep < s) v = wlog[i].data;
    return v;
  endfunction

  task automatic model_txn(input logic rs, input logic [7:0] d, input int extra);
    txn_t t;
    t.rs   = rs;
    t.data = d;
    t.step = model_step + 2;
    exp_q.push_back(t);
    model_step += 3 + extra;
  endtask

  task automatic model_init();
    model_txn(1'b0, 8'h38, 0);
    model_txn(1'b0, 8'h0C, 0);
    model_txn(1'b0, 8'h01, 2);
    model_txn(1'b0, 8'h06, 0);
  endtask

  task automatic model_frame();
    model_txn(1'b0, 8'h80, 0);
    for (int k = 0; k < 16; k++) model_txn(1'b1, char_at(k, model_step + 1), 0);
    model_txn(1'b0, 8'hC0, 0);
    for (int k = 16; k < 32; k++) model_txn(1'b1, char_at(k, model_step + 1), 0);
    exp_fd.push_back(model_step);
  endtask

  task automatic test_reset();
    txn_t got, want;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    reset    = 1'b1;
    step_clk = 1'b1;
    tick(5);
    reset = 1'b0;
    clear_model();
    tick(100);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: saw %0d enable pulses, expected 0", mon_q.size());
    end
    checks++;
    if ({bus.lcd_data, bus.lcd_rs, bus.lcd_rw, bus.lcd_en, bus.init_done, bus.frame_done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: data=%02h rs=%0b rw=%0b en=%0b init=%0b frame=%0b, expected all 0",
               bus.lcd_data, bus.lcd_rs, bus.lcd_rw, bus.lcd_en, bus.init_done, bus.frame_done);
    end
  endtask

  task automatic test_init(input string tag);
    txn_t got, want;
    model_init();
    run_steps(13, 1'b0);
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_init_early: init_done=%0b before ENTRY_MODE hold, expected 0", tag, bus.init_done);
    end
    run_steps(1, 1'b0);
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_init_done: init_done=%0b after ENTRY_MODE hold, expected 1", tag, bus.init_done);
    end
    while (mon_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      if (mon_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_txn_count: %0d seen left, %0d expected left", tag, mon_q.size(), exp_q.size());
        mon_q.delete();
        exp_q.delete();
      end else begin
        got  = mon_q.pop_front();
        want = exp_q.pop_front();
        if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
          errors++;
          $display("FAIL %s_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                   tag, got.rs, got.data, got.step, want.rs, want.data, want.step);
        end
      end
    end
  endtask

  task automatic test_hello();
    txn_t got, want;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) write_buf(5'(i), hello[i]);
    model_frame();
    run_steps(102, 1'b0);
    while (mon_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      if (mon_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL hello_txn_count: %0d seen left, %0d expected left", mon_q.size(), exp_q.size());
        mon_q.delete();
        exp_q.delete();
      end else begin
        got  = mon_q.pop_front();
        want = exp_q.pop_front();
        if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
          errors++;
          $display("FAIL hello_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                   got.rs, got.data, got.step, want.rs, want.data, want.step);
        end
      end
    end
    checks++;
    if (fd_q.size() != 1 || exp_fd.size() != 1 || fd_q[0] != exp_fd[0]) begin
      errors++;
      $display("FAIL hello_frame_done: %0d pulses (first at step %0d), expected 1 at step %0d",
               fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, (exp_fd.size() > 0) ? exp_fd[0] : -1);
    end
    fd_q.delete();
    exp_fd.delete();
  endtask

  task automatic test_write_collision();
    txn_t got, want;
    int f0, s;
    f0 = model_step;
    s  = f0 + 7 + 3 * 20;
    run_steps(s - f0 - 1, 1'b0);
    do_step(1'b1, 5'd20, 8'h41);
    run_steps(204 - (s - f0), 1'b0);
    model_frame();
    model_frame();
    checks++;
    if (mon_q.size() < 57 || mon_q[22].data !== 8'h20 || mon_q[56].data !== 8'h41) begin
      errors++;
      $display("FAIL collision_bytes: frame1=%02h frame2=%02h (pulses %0d), expected 20 then 41",
               (mon_q.size() > 22) ? mon_q[22].data : 8'hxx, (mon_q.size() > 56) ? mon_q[56].data : 8'hxx,
               mon_q.size());
    end
    while (mon_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      if (mon_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL collision_txn_count: %0d seen left, %0d expected left", mon_q.size(), exp_q.size());
        mon_q.delete();
        exp_q.delete();
      end else begin
        got  = mon_q.pop_front();
        want = exp_q.pop_front();
        if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
          errors++;
          $display("FAIL collision_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                   got.rs, got.data, got.step, want.rs, want.data, want.step);
        end
      end
    end
    fd_q.delete();
    exp_fd.delete();
  endtask

  task automatic test_back_to_back();
    txn_t got, want;
    for (int i = 0; i < 6; i++) write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    run_steps(306, 1'b1);
    model_frame();
    model_frame();
    model_frame();
    while (mon_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      if (mon_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_txn_count: %0d seen left, %0d expected left", mon_q.size(), exp_q.size());
        mon_q.delete();
        exp_q.delete();
      end else begin
        got  = mon_q.pop_front();
        want = exp_q.pop_front();
        if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
          errors++;
          $display("FAIL b2b_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                   got.rs, got.data, got.step, want.rs, want.data, want.step);
        end
      end
    end
    checks++;
    if (fd_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_frame_count: %0d frame_done pulses, expected 3", fd_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fd_q[i] != exp_fd[i] || (i > 0 && fd_q[i] - fd_q[i-1] != 102)) begin
          errors++;
          $display("FAIL b2b_frame_step: pulse %0d at step %0d, expected step %0d (102 apart)",
                   i, fd_q[i], exp_fd[i]);
        end
      end
    end
    fd_q.delete();
    exp_fd.delete();
  endtask

  task automatic test_reset_mid();
    txn_t got, want;
    int seen;
    model_frame();
    run_steps(25, 1'b0);
    step_clk = 1'b0;
    tick(5);
    step_clk = 1'b1;
    step_cnt++;
    tick(1);
    checks++;
    if (bus.lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse: lcd_en=%0b on char 7 pulse step, expected 1", bus.lcd_en);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (bus.lcd_en !== 1'b0 || bus.init_done !== 1'b0 || bus.lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: en=%0b init_done=%0b data=%02h after reset, expected 0 0 00",
               bus.lcd_en, bus.init_done, bus.lcd_data);
    end
    seen = mon_q.size();
    checks++;
    if (seen != 9) begin
      errors++;
      $display("FAIL mid_partial_count: %0d pulses before reset, expected 9", seen);
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      got  = mon_q.pop_front();
      want = exp_q.pop_front();
      if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
        errors++;
        $display("FAIL mid_partial_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                 got.rs, got.data, got.step, want.rs, want.data, want.step);
      end
    end
    reset = 1'b0;
    clear_model();
    tick(20);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL mid_release_pulse: %0d pulses after release with step_clk high, expected 0", mon_q.size());
    end
    test_init("reinit");
    model_frame();
    run_steps(102, 1'b0);
    while (mon_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      if (mon_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL blank_txn_count: %0d seen left, %0d expected left", mon_q.size(), exp_q.size());
        mon_q.delete();
        exp_q.delete();
      end else begin
        got  = mon_q.pop_front();
        want = exp_q.pop_front();
        if (got.rs !== want.rs || got.data !== want.data || got.step !== want.step) begin
          errors++;
          $display("FAIL blank_txn: got rs=%0b data=%02h step=%0d, expected rs=%0b data=%02h step=%0d",
                   got.rs, got.data, got.step, want.rs, want.data, want.step);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_hello();
    test_write_collision();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (fd_wide != 0) begin
      errors++;
      $display("FAIL frame_done_width: %0d multi-cycle pulses, expected 0", fd_wide);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_step_controller.md
Name: lcd_step_controller

Overview:
- Downstream consumer of the LCD clock divider's slow square wave. Drives a 2x16 HD44780-style character LCD in 8-bit write-only mode.
- Edge-detects the divider output in the system clock domain; each detected rising edge advances the LCD bus by one phase.
- Runs a fixed power-up init sequence, then continuously refreshes both lines from an internal 32-byte character buffer that a host writes at full clock rate.

Parameters:
- FUNC_SET, 8'h38, function-set command (8-bit bus, 2 lines, 5x8 font).
- DISP_CTRL, 8'h0C, display on, cursor off, blink off.
- ENTRY_MODE, 8'h06, increment address, no shift.
- CLEAR_WAIT_STEPS, 2, idle steps inserted after the clear command (0x01).

Ports:
- clock_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- step_clk  input  1  divider output; each rising edge is one step
- wr_en  input  1  buffer write strobe
- wr_addr  input  5  buffer index: 0-15 is line 1, 16-31 is line 2
- wr_data  input  8  character code
- lcd_data  output  8  LCD data bus
- lcd_rs  output  1  0 = command, 1 = data
- lcd_rw  output  1  constant 0
- lcd_en  output  1  LCD enable strobe
- init_done  output  1  high once the init sequence has completed
- frame_done  output  1  one-cycle pulse at the end of each full refresh

Behaviour:
- Single clock domain. Everything, including the edge detect, is clocked on clock_in. step_clk is never used as a clock.
- Edge detect: step = step_clk & ~step_prev. step_prev resets to 1, so a step_clk that is high at reset release does not produce a step.
- Reset values: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, init_done=0, frame_done=0. The buffer resets to 8'h20 (space) in every entry. The FSM resets to INIT, command index 0, phase SETUP.
- Reset mid-transaction: lcd_en is 0 in the cycle after reset is sampled, and the init sequence restarts from the beginning.
- Transaction: every command or data byte takes 3 steps.
  - SETUP: drive lcd_rs and lcd_data, lcd_en=0.
  - PULSE: lcd_en=1.
  - HOLD: lcd_en=0.
  - lcd_data and lcd_rs stay stable from SETUP through HOLD. Outputs change only in the cycle after a step.
- Sequence:
  - INIT: FUNC_SET, DISP_CTRL, 0x01, then CLEAR_WAIT_STEPS idle steps with lcd_en=0, then ENTRY_MODE.
  - init_done rises in the cycle after the HOLD step of ENTRY_MODE and stays high until reset.
  - ADDR1: command 0x80. CHARS1: data buf[0..15].
  - ADDR2: command 0xC0. CHARS2: data buf[16..31].
  - After the HOLD step of buf[31], frame_done pulses for one cycle and the FSM loops to ADDR1. It does not re-run INIT.
- Buffer writes: accepted on any cycle wr_en=1, independent of steps.
  - The character byte is sampled into lcd_data at its SETUP step.
  - If a write to index k and the SETUP step of index k fall in the same cycle, the old value is sent. The new value appears on the next refresh.
- Index counter: 5 bits. The wrap from 31 to 0 coincides with frame_done.
- No step pending: outputs hold indefinitely.

Decomposition:
- Shared package: HD44780 command constants (CLEAR=8'h01, LINE1_ADDR=8'h80, LINE2_ADDR=8'hC0), the FSM state encoding (INIT, ADDR1, CHARS1, ADDR2, CHARS2), and the phase encoding (SETUP, PULSE, HOLD).
- One natural sub-module: lcd_step_edge, the rising-edge detector for step_clk.
- The character buffer and FSM stay in the top level.

Test Plan:
- Reset with step_clk=1, release, hold step_clk=1 for 100 cycles -> no lcd_en pulse, all outputs 0.
- Toggle step_clk with a period of 10 cycles:
  - First lcd_en pulse carries lcd_rs=0, lcd_data=8'h38.
  - Following pulses carry 8'h0C, then 8'h01.
  - Exactly 2 empty steps follow before the 8'h06 pulse.
  - init_done rises after the 8'h06 HOLD step.
- Write "HELLO" at indices 0-4, then run one frame:
  - 8'h80 is sent with rs=0.
  - Data bytes with rs=1 are 48,45,4C,4C,4F, then eleven 8'h20.
  - 8'hC0 is sent with rs=0, then 16 bytes of 8'h20.
  - frame_done pulses exactly once.
- Write 8'h41 to index 20 in the same cycle as that index's SETUP step -> 8'h20 is sent this frame and 8'h41 on the next frame.
- Assert reset during the PULSE step of char index 7 -> lcd_en=0 the next cycle, init_done=0, next transaction is 8'h38.
- Run 3 consecutive frames -> frame_done pulses 3 times, spaced 102 steps apart ((2 + 32) transactions x 3 steps).
